fp_div_scheduler: RTL

- Shares one fp_divider instance between two requesters using round-robin arbitration.
- Latches the granted operands and holds them on the divider inputs for the whole operation.
- Generates the divider's fp_clk strobe and counts int_clk cycles until the quotient is valid.
- Returns the quotient on a valid/ready response port tagged with the requester id; divide-by-zero is short-circuited without running the divider.

---
 rtl/fp_div_scheduler_if.sv | 46 ++++
 rtl/fp_div_scheduler.sv | 119 +++++++++++
 2 files changed

// File: rtl/fp_div_scheduler_if.sv
// Request, divider and response signals of the shared fp_divider scheduler.
// The scheduler uses the slave modport; the surrounding system uses master.
interface fp_div_scheduler_if;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_fp_clk;
  logic [31:0] div_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_dz;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output div_a, div_b, div_fp_clk,
    input  div_out,
    output rsp_valid,
    input  rsp_ready,
    output rsp_id, rsp_data, rsp_dz, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  div_a, div_b, div_fp_clk,
    output div_out,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_id, rsp_data, rsp_dz, busy
  );
endinterface

// File: rtl/fp_div_scheduler.sv
// Round-robin scheduler sharing one multi-cycle fp_divider between two requesters,
// with divide-by-zero short-circuited straight to the response register.
module fp_div_scheduler #(
  parameter int LATENCY    = 50,
  parameter int FPCLK_FALL = 26,
  parameter int CNT_W      = 6
) (
  input logic           int_clk,
  input logic           reset_n,
  fp_div_scheduler_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CNT_W-1:0] FALL_CNT = CNT_W'(FPCLK_FALL - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY);

  logic [1:0]       state;
  logic             ptr;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      div_a_q;
  logic [31:0]      div_b_q;
  logic             fp_clk_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_dz_q;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             gnt_id;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             sel_dz;

  // ptr names the requester that wins when both are valid
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | (ptr == 1'b0));
    grant1 = bus.req1_valid & (~bus.req0_valid | (ptr == 1'b1));
    accept = (state == IDLE) & (grant0 | grant1);
    gnt_id = grant1;
    sel_a  = gnt_id ? bus.req1_a : bus.req0_a;
    sel_b  = gnt_id ? bus.req1_b : bus.req0_b;
    sel_dz = (sel_b[30:23] == 8'h00) & (sel_b[22:0] == 23'h0);
  end

  assign bus.req0_ready = (state == IDLE) & grant0;
  assign bus.req1_ready = (state == IDLE) & grant1;
  assign bus.busy       = (state != IDLE);
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;
  assign bus.div_fp_clk = fp_clk_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_dz     = rsp_dz_q;

  always_ff @(posedge int_clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      cnt         <= '0;
      div_a_q     <= 32'h0;
      div_b_q     <= 32'h0;
      fp_clk_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_dz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_a_q  <= sel_a;
            div_b_q  <= sel_b;
            rsp_id_q <= gnt_id;
            cnt      <= '0;
            ptr      <= ~gnt_id;
            // A zero divisor never reaches the divider: answer with signed infinity
            if (sel_dz) begin
              rsp_data_q  <= {sel_a[31] ^ sel_b[31], 8'hFF, 23'h0};
              rsp_dz_q    <= 1'b1;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              rsp_dz_q <= 1'b0;
              fp_clk_q <= 1'b1;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == FALL_CNT) begin
            fp_clk_q <= 1'b0;
          end
          if (cnt == LAST_CNT) begin
            rsp_data_q  <= bus.div_out;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_dz_q    <= 1'b0;
            fp_clk_q    <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
